// File: rtl/regfile.sv
// regfile -- eight-entry, 16-bit general-purpose register file with
// A/B operand latches and a written-since-reset mask.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high; clears registers, A, B and written
//   data_in   write-back value
//   write     write enable; R[writenum] <= data_in
//   writenum  destination register index
//   readnum   read-port register index
//   loada     A <= data_out
//   loadb     B <= data_out
//   data_out  combinational read of R[readnum]
//   A, B      operand latches feeding the shifter/ALU stage
//   written   bit n set once register n has been written since reset
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a write to the register being read is forwarded to
//   data_out in the same cycle, so a latch loading in that cycle captures
//   the new value. When undefined, data_out always reflects stored state.

module regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write,
  input  logic [2:0]       writenum,
  input  logic [2:0]       readnum,
  input  logic             loada,
  input  logic             loadb,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [NREGS-1:0] written
);

  // Registers must all clear on reset, so they are built as flops rather
  // than a RAM; each register's output is gathered into this read array.
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] stored_rd;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [NREGS-1:0] written_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [WIDTH-1:0] value_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          value_reg <= '0;
        end else if (write && (writenum == 3'(gi))) begin
          value_reg <= data_in;
        end
      end

      assign regs_q[gi] = value_reg;
    end
  endgenerate

  assign stored_rd = regs_q[readnum];

`ifdef REGFILE_BYPASS_EN
  // Forwarding is purely combinational and is not gated by reset; reset
  // only takes effect at the edge.
  assign data_out = (write && (writenum == readnum)) ? data_in : stored_rd;
`else
  assign data_out = stored_rd;
`endif

  // Operand latches sample data_out as seen just before the edge, so a
  // same-cycle write to the read register is captured old (no bypass) or
  // new (bypass) purely through the data_out mux above.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      written_reg <= '0;
    end else begin
      if (loada) begin
        a_reg <= data_out;
      end
      if (loadb) begin
        b_reg <= data_out;
      end
      if (write) begin
        written_reg[writenum] <= 1'b1;
      end
    end
  end

  assign A       = a_reg;
  assign B       = b_reg;
  assign written = written_reg;

`ifndef SYNTHESIS
  // An unknown destination index would corrupt an arbitrary register.
  always_ff @(posedge clk) begin
    if (write) begin
      assert (!$isunknown(writenum));
    end
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// tb_regfile -- directed vector table, hand-written reset-mid-sequence
// checks, and a randomized run against a behavioural model of regfile.

module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        write;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [15:0] data_out;
  logic [15:0] A;
  logic [15:0] B;
  logic [7:0]  written;

  int n_checks = 0;
  int n_fail   = 0;

  regfile dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .write    (write),
    .writenum (writenum),
    .readnum  (readnum),
    .loada    (loada),
    .loadb    (loadb),
    .data_out (data_out),
    .A        (A),
    .B        (B),
    .written  (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [2:0]  wn;
    logic [15:0] din;
    logic [2:0]  rn;
    logic        la;
    logic        lb;
    logic        chk_dout;
    logic [15:0] dout;   // expected data_out just before the edge
    logic [15:0] a;      // expected A after the edge
    logic [15:0] b;      // expected B after the edge
    logic [7:0]  w;      // expected written after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic wr, input logic [2:0] wn,
                              input logic [15:0] din, input logic [2:0] rn,
                              input logic la, input logic lb, input logic chk_dout,
                              input logic [15:0] dout, input logic [15:0] a,
                              input logic [15:0] b, input logic [7:0] w);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wn = wn; v.din = din; v.rn = rn;
    v.la = la; v.lb = lb; v.chk_dout = chk_dout;
    v.dout = dout; v.a = a; v.b = b; v.w = w;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check data_out before the
  // rising edge, then check the latches and mask 1 time unit after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; write = v.wr; writenum = v.wn; data_in = v.din;
    readnum = v.rn; loada = v.la; loadb = v.lb;
    #1;
    if (v.chk_dout) check({tag, " data_out"}, data_out, v.dout);
    @(posedge clk);
    #1;
    check({tag, " A"}, A, v.a);
    check({tag, " B"}, B, v.b);
    check({tag, " written"}, {8'h00, written}, {8'h00, v.w});
    $display("%s rst=%0d wr=%0d wn=%0d din=%h rn=%0d la=%0d lb=%0d dout=%h A=%h B=%h written=%h",
             tag, v.rst, v.wr, v.wn, v.din, v.rn, v.la, v.lb, data_out, A, B, written);
  endtask

  // Behavioural model for the random phase.
  logic [15:0] m_regs [8];
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [7:0]  m_w;

  initial begin
    logic [15:0] sc_a;
    logic [7:0]  w_acc;
    vec_t v;
    reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
    readnum = '0; loada = 1'b0; loadb = 1'b0;

    sc_a = BYPASS ? 16'h00AA : 16'h0011;

    // Reset and empty sweep.
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00));
    for (int n = 0; n < 8; n++)
      vecs.push_back(mk(0, 0, 0, 16'h0000, 3'(n), 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00));
    // R3, R7 writes and readback.
    vecs.push_back(mk(0, 1, 3, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'h08));
    vecs.push_back(mk(0, 1, 7, 16'h1234, 3, 0, 0, 1, 16'hBEEF, 16'h0000, 16'h0000, 8'h88));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 7, 0, 0, 1, 16'h1234, 16'h0000, 16'h0000, 8'h88));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 5, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'h88));
    // Operand latch loads, then hold across idle cycles.
    vecs.push_back(mk(0, 1, 2, 16'h0005, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'h8C));
    vecs.push_back(mk(0, 1, 5, 16'h0003, 2, 1, 0, 1, 16'h0005, 16'h0005, 16'h0000, 8'hAC));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 5, 0, 1, 1, 16'h0003, 16'h0005, 16'h0003, 8'hAC));
    for (int n = 0; n < 4; n++)
      vecs.push_back(mk(0, 0, 0, 16'h0000, 7, 0, 0, 1, 16'h1234, 16'h0005, 16'h0003, 8'hAC));
    // Same-cycle write and load of R1.
    vecs.push_back(mk(0, 1, 1, 16'h0011, 0, 0, 0, 1, 16'h0000, 16'h0005, 16'h0003, 8'hAE));
    vecs.push_back(mk(0, 1, 1, 16'h00AA, 1, 1, 0, 1, sc_a, sc_a, 16'h0003, 8'hAE));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h00AA, sc_a, 16'h0003, 8'hAE));
    // Fill all registers, read back, then reset with a write pending.
    w_acc = 8'hAE;
    for (int n = 0; n < 8; n++) begin
      w_acc[n] = 1'b1;
      vecs.push_back(mk(0, 1, 3'(n), 16'h1000 + 16'(n), 0, 0, 0, 0, 16'h0000, sc_a, 16'h0003, w_acc));
    end
    for (int n = 0; n < 8; n++)
      vecs.push_back(mk(0, 0, 0, 16'h0000, 3'(n), 0, 0, 1, 16'h1000 + 16'(n), sc_a, 16'h0003, 8'hFF));
    vecs.push_back(mk(1, 1, 4, 16'hFFFF, 4, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00));
    for (int n = 0; n < 8; n++)
      vecs.push_back(mk(0, 0, 0, 16'h0000, 3'(n), 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset between a write and the load that depends on it.
    apply(mk(0, 1, 6, 16'hABCD, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'h40), "seq_wr6");
    apply(mk(0, 0, 0, 16'h0000, 6, 0, 0, 1, 16'hABCD, 16'h0000, 16'h0000, 8'h40), "seq_rd6");
    apply(mk(1, 1, 2, 16'h5555, 6, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00), "seq_rst");
    apply(mk(0, 0, 0, 16'h0000, 6, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00), "seq_ld6");
    apply(mk(0, 0, 0, 16'h0000, 2, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00), "seq_rd2");

    // Random phase: first cycle forces reset so the model starts known.
    for (int k = 0; k < 8; k++) m_regs[k] = 16'h0000;
    m_a = 16'h0000; m_b = 16'h0000; m_w = 8'h00;
    for (int c = 0; c < 1000; c++) begin
      logic [15:0] exp_dout;
      v.rst = (c == 0) || ($urandom_range(0, 49) == 0);
      v.wr  = 1'($urandom_range(0, 1));
      v.wn  = 3'($urandom_range(0, 7));
      v.din = 16'($urandom);
      v.rn  = 3'($urandom_range(0, 7));
      v.la  = ($urandom_range(0, 3) == 0);
      v.lb  = ($urandom_range(0, 3) == 0);
      exp_dout = (BYPASS && v.wr && (v.wn == v.rn)) ? v.din : m_regs[v.rn];
      if (v.rst) begin
        for (int k = 0; k < 8; k++) m_regs[k] = 16'h0000;
        m_a = 16'h0000; m_b = 16'h0000; m_w = 8'h00;
      end else begin
        if (v.la) m_a = exp_dout;
        if (v.lb) m_b = exp_dout;
        if (v.wr) begin
          m_regs[v.wn] = v.din;
          m_w[v.wn] = 1'b1;
        end
      end
      v.chk_dout = !v.rst;
      v.dout = exp_dout;
      v.a = m_a; v.b = m_b; v.w = m_w;
      apply(v, $sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile.md
# regfile

Eight-entry, 16-bit general-purpose register file for the RISC datapath. It sits directly downstream of the write-back mux. It captures `data_in` into the register selected by `writenum` when `write` is high. It also holds the A and B operand latches that feed the shifter/ALU stage, and tracks which registers have been written since reset.

## Interface
- `WIDTH`, 16, data width of every register and data port
- `NREGS`, 8, number of registers; fixed at 8 because `writenum`/`readnum` are 3 bits
- `clk`  input  1  rising-edge clock; the only clock
- `reset`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`
- `data_in`  input  16  write-back value from the write-back mux
- `write`  input  1  write enable for the register file
- `writenum`  input  3  destination register index
- `readnum`  input  3  source register index for the read port
- `loada`  input  1  capture `data_out` into operand latch A
- `loadb`  input  1  capture `data_out` into operand latch B
- `data_out`  output  16  combinational read of register `readnum`
- `A`  output  16  operand latch A
- `B`  output  16  operand latch B
- `written`  output  8  bit n set once register n has been written since reset

## Operation
- Storage: R0..R7, each 16 bits. No register is hardwired; R0 is writable.
- Write: on a rising edge with `write`=1 and `reset`=0, R[`writenum`] <= `data_in`. Only one register is written per cycle. No other register changes.
- Read: `data_out` = R[`readnum`]. This is combinational from the current register state, except as modified under Configuration.
- Operand latches:
  - On an edge with `loada`=1, A <= `data_out`.
  - On an edge with `loadb`=1, B <= `data_out`.
  - Both may be high in the same cycle; both then capture the same `data_out` value.
  - A latch with its load low holds its value.
- Written mask: on an edge with `write`=1, `written[writenum]` <= 1. Bits are sticky; only `reset` clears them.
- Reset has priority over every other input. On an edge with `reset`=1:
  - R0..R7 <= 0, A <= 0, B <= 0, `written` <= 8'h00.
  - `write`, `loada` and `loadb` are ignored in that cycle.
- Reset values: every register 0, `A`=0, `B`=0, `written`=0. After reset `data_out`=0 for every `readnum`.
- X on `writenum` while `write`=1 is illegal. A checker must flag it.

## Timing
- Write latency: 1 cycle. A value written at edge N is visible on `data_out` after edge N without bypass.
- Read latency: 0 cycles. `data_out` follows `readnum` combinationally.
- Load latency: A and B update at the edge where `loada`/`loadb` is sampled high. They hold the `data_out` value present just before that edge.
- Write and load in the same cycle, same register, without bypass: the latch captures the OLD register value. The register takes the new value.
- Reset asserted mid-sequence, e.g. between a write and a dependent load: all state is 0 after the reset edge. Operations pending in the reset cycle are lost.
- No handshake. The upstream controller sequences `write`/`loada`/`loadb` one cycle apart.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: when `write`=1 and `writenum`==`readnum`, `data_out` = `data_in` in the same cycle (write-to-read forwarding). A latch loading in that cycle therefore captures the NEW value. The register array update is unchanged.
- Not defined: `data_out` always reflects stored state. Same-cycle write/read of one register returns the old value.
- `reset` overrides forwarding only at the edge. The combinational bypass path is active whenever `write`=1, including during a reset cycle. Benches must not check `data_out` during reset cycles.

## Test plan
- Reset, then sweep `readnum` 0..7 -> `data_out`=16'h0000 each; `A`=`B`=0; `written`=8'h00.
- Write R3=16'hBEEF, R7=16'h1234 on consecutive edges, then read 3 and 7 -> 16'hBEEF and 16'h1234; `written`=8'h88; other registers still 0.
- Preload R2=16'h0005; `readnum`=2, `loada`=1; next cycle R5=16'h0003, `readnum`=5, `loadb`=1 -> `A`=16'h0005, `B`=16'h0003. Latches then hold across 4 idle cycles.
- Same cycle: R1=16'h0011 stored; `write`=1, `writenum`=1, `data_in`=16'h00AA, `readnum`=1, `loada`=1 -> `A`=16'h0011 without `REGFILE_BYPASS_EN`, 16'h00AA with it; R1=16'h00AA in both builds.
- Write all eight registers with 16'h1000+n, then `reset`=1 with `write`=1, `writenum`=4, `data_in`=16'hFFFF -> all registers 0, `written`=0, R4 reads 0 after the reset edge.
- Random write/read/load sequence of 1000 cycles against a reference model -> `data_out`, `A`, `B` and `written` match every cycle.
